// File: rtl/rr_unit.sv
// -----------------------------------------------------------------------------
// rr_unit -- result register and sequencing stage of the add/multiply datapath.
//
// Holds the 2N-bit result register RR, captures the external adder output and
// steers the adder's second operand through y9. Performs a one-step signed
// addition or an N-step unsigned shift-and-add multiplication, with a
// start/busy/done handshake toward the control unit.
//
// Parameters:
//   N        operand width; rr and the adder bus are 2N bits wide
//
// Ports:
//   clk      in   clock, all state updates on the rising edge
//   rst_n    in   synchronous active-low reset
//   start    in   request a new operation (sampled only in IDLE)
//   op       in   0 = addition, 1 = multiplication (sampled with start)
//   ra       in   [N-1:0]   multiplier operand (sampled with start)
//   sm_in    in   [2N-1:0]  adder output
//   rr       out  [2N-1:0]  result register
//   y9       out  adder operand select: 0 = sign-extended RB, 1 = RR
//   k        out  current multiplication step; upstream shifts RB by k
//   busy     out  high in every state except IDLE
//   done     out  one-cycle pulse, result valid in rr
//
// Build option:
//   RR_ZERO_SKIP_EN  when defined, multiplication ends as soon as the
//                    remaining multiplier bits are all zero.
// -----------------------------------------------------------------------------
module rr_unit #(
  parameter  int N  = 4,
  localparam int KW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            op,
  input  logic [N-1:0]    ra,
  input  logic [2*N-1:0]  sm_in,
  output logic [2*N-1:0]  rr,
  output logic            y9,
  output logic [KW-1:0]   k,
  output logic            busy,
  output logic            done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADD,
    S_INIT,
    S_MUL,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [2*N-1:0]   rr_q, rr_d;
  logic [N-1:0]     mq_q, mq_d;
  logic [KW-1:0]    k_q, k_d;
  logic             y9_q, y9_d;
  logic             last_step;

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    mq_d      = mq_q;
    k_d       = k_q;
    last_step = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (op) begin
            state_d = S_INIT;
            mq_d    = ra;
          end else begin
            state_d = S_ADD;
          end
        end
      end

      S_ADD: begin
        rr_d    = sm_in;
        state_d = S_DONE;
      end

      S_INIT: begin
        rr_d    = '0;
        k_d     = '0;
        state_d = S_MUL;
      end

      S_MUL: begin
        // The adder is presenting rr + (RB << k); keep it only for a set bit.
        if (mq_q[0]) begin
          rr_d = sm_in;
        end
        mq_d      = mq_q >> 1;
        k_d       = k_q + KW'(1);
        last_step = (k_q == KW'(N - 1));
`ifdef RR_ZERO_SKIP_EN
        // No set bits remain: further steps would never write rr.
        if (mq_d == '0) begin
          last_step = 1'b1;
        end
`else
`endif
        if (last_step) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Registered select so it is stable for the whole cycle it applies to.
    y9_d = (state_d == S_INIT) || (state_d == S_MUL);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rr_q    <= '0;
      mq_q    <= '0;
      k_q     <= '0;
      y9_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      mq_q    <= mq_d;
      k_q     <= k_d;
      y9_q    <= y9_d;
    end
  end

  assign rr   = rr_q;
  assign y9   = y9_q;
  assign k    = k_q;
  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_rr_unit.sv
// -----------------------------------------------------------------------------
// tb_rr_unit -- directed self-checking bench for rr_unit with N=4.
// The adder is modelled as sm_in = y9 ? rr + (rb << k) : sign-extended rb.
// Outputs are sampled on the falling edge; T0 is the rising edge sampling start.
// -----------------------------------------------------------------------------
module tb_rr_unit;

  localparam int N = 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         op;
  logic [3:0]   ra;
  logic [3:0]   rb;
  logic [7:0]   sm_in;
  logic [7:0]   rr;
  logic         y9;
  logic [1:0]   k;
  logic         busy;
  logic         done;

  int errors;
  int checks;

  rr_unit #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .ra    (ra),
    .sm_in (sm_in),
    .rr    (rr),
    .y9    (y9),
    .k     (k),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    sm_in = {{4{rb[3]}}, rb};
    if (y9) sm_in = rr + ({4'b0000, rb} << k);
  end

`ifdef RR_ZERO_SKIP_EN
  localparam int LAT_ZERO = 2;
  localparam int LAT_ONE  = 2;
`else
  localparam int LAT_ZERO = 5;
  localparam int LAT_ONE  = 5;
`endif

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; op = 1'b0; ra = 4'd0; rb = 4'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (rr !== 8'h00)   begin errors++; $display("FAIL reset_rr got=%h exp=00", rr); end
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0)  begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (k !== 2'd0)     begin errors++; $display("FAIL reset_k got=%0d exp=0", k); end
    checks++; if (y9 !== 1'b0)    begin errors++; $display("FAIL reset_y9 got=%b exp=0", y9); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add();
    start = 1'b1; op = 1'b0; rb = 4'b1001;
    @(posedge clk);                       // T0
    @(negedge clk);
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL add_busy_t0 got=%b exp=1", busy); end
    checks++; if (y9 !== 1'b0)   begin errors++; $display("FAIL add_y9_t0 got=%b exp=0", y9); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL add_done_t0 got=%b exp=0", done); end
    @(posedge clk);                       // T1
    @(negedge clk);
    checks++; if (rr !== 8'hF9)  begin errors++; $display("FAIL add_rr_t1 got=%h exp=f9", rr); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL add_done_t1 got=%b exp=1", done); end
    checks++; if (y9 !== 1'b0)   begin errors++; $display("FAIL add_y9_t1 got=%b exp=0", y9); end
    @(posedge clk);                       // T2
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL add_done_t2 got=%b exp=0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL add_busy_t2 got=%b exp=0", busy); end
    checks++; if (rr !== 8'hF9)  begin errors++; $display("FAIL add_rr_hold got=%h exp=f9", rr); end
  endtask

  task automatic test_mul_steps();
    start = 1'b1; op = 1'b1; ra = 4'b1011; rb = 4'd13;
    @(posedge clk);                       // T0
    @(negedge clk);
    start = 1'b0; ra = 4'd0;
    checks++; if (y9 !== 1'b1) begin errors++; $display("FAIL mul_y9_init got=%b exp=1", y9); end
    for (int j = 0; j < N; j++) begin
      @(posedge clk);                     // T(1+j)
      @(negedge clk);
      checks++; if (k !== 2'(j))   begin errors++; $display("FAIL mul_k_step%0d got=%0d exp=%0d", j, k, j); end
      checks++; if (y9 !== 1'b1)   begin errors++; $display("FAIL mul_y9_step%0d got=%b exp=1", j, y9); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL mul_done_step%0d got=%b exp=0", j, done); end
    end
    @(posedge clk);                       // T5
    @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL mul_done_t5 got=%b exp=1", done); end
    checks++; if (rr !== 8'h8F)  begin errors++; $display("FAIL mul_rr_t5 got=%h exp=8f", rr); end
    checks++; if (y9 !== 1'b0)   begin errors++; $display("FAIL mul_y9_t5 got=%b exp=0", y9); end
    @(posedge clk);                       // T6
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL mul_done_t6 got=%b exp=0", done); end
  endtask

  // Runs one multiplication for a fixed window, recording where done appears.
  // inj > 0 pulses start with op=0 so that it is sampled at T(inj+1).
  task automatic run_mul(input logic [3:0] ra_v, input logic [3:0] rb_v,
                         input logic [7:0] exp_rr, input int exp_idx,
                         input int inj, input string name);
    int first_idx;
    int n_done;
    logic [7:0] rr_at_done;
    first_idx = 0; n_done = 0; rr_at_done = 8'hxx;
    start = 1'b1; op = 1'b1; ra = ra_v; rb = rb_v;
    @(posedge clk);                       // T0
    @(negedge clk);
    start = 1'b0; ra = 4'd0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done === 1'b1) begin
        n_done++;
        if (first_idx == 0) begin
          first_idx  = i;
          rr_at_done = rr;
        end
      end
      start = (inj != 0) && (i == inj);
      op    = 1'b0;
    end
    start = 1'b0;
    checks++; if (first_idx != exp_idx) begin errors++; $display("FAIL %s_done_edge got=T%0d exp=T%0d", name, first_idx, exp_idx); end
    checks++; if (n_done != 1) begin errors++; $display("FAIL %s_done_count got=%0d exp=1", name, n_done); end
    checks++; if (rr_at_done !== exp_rr) begin errors++; $display("FAIL %s_rr got=%h exp=%h", name, rr_at_done, exp_rr); end
  endtask

  task automatic test_zero_operand();
    run_mul(4'b0000, 4'd15, 8'h00, LAT_ZERO, 0, "zero_ra");
  endtask

  task automatic test_zero_skip();
    run_mul(4'b0001, 4'd7, 8'h07, LAT_ONE, 0, "zero_skip");
  endtask

  task automatic test_busy_protect();
    run_mul(4'b1011, 4'd13, 8'h8F, 5, 2, "busy_protect");
  endtask

  task automatic test_reset_mid_op();
    start = 1'b1; op = 1'b1; ra = 4'b1011; rb = 4'd13;
    @(posedge clk);                       // T0
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);                       // T1
    @(posedge clk);                       // T2, step 0 wrote rr
    @(negedge clk);
    checks++; if (rr !== 8'h0D) begin errors++; $display("FAIL midrst_pre_rr got=%h exp=0d", rr); end
    rst_n = 1'b0;
    @(posedge clk);                       // T3, reset edge
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if (rr !== 8'h00)  begin errors++; $display("FAIL midrst_rr got=%h exp=00", rr); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done got=%b exp=0", done); end
    checks++; if (k !== 2'd0)    begin errors++; $display("FAIL midrst_k got=%0d exp=0", k); end
    checks++; if (y9 !== 1'b0)   begin errors++; $display("FAIL midrst_y9 got=%b exp=0", y9); end
    test_add();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_add();
    test_mul_steps();
    test_zero_operand();
    test_zero_skip();
    test_busy_protect();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
